// File: rtl/led_sequencer.sv
// Multi-channel LED sequencer: each channel is off, on, blinking or bursting,
// all timed from one shared free-running counter with a 2^sel half-period.
module led_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 27,
    parameter int SEL_W      = 5,
    parameter int BURST_N    = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [SEL_W*NUM_CH-1:0] sel,
    input  logic [NUM_CH-1:0]       trig,
    output logic [NUM_CH-1:0]       led,
    output logic [NUM_CH-1:0]       busy
);
    localparam int BW = $clog2(BURST_N + 1);
    localparam logic [BW-1:0] BURST_LOAD = BW'(BURST_N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_OFF  = 2'd3;

    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] trig_q;
    logic [NUM_CH-1:0] trigRise;
    logic [NUM_CH-1:0] ledRaw;

    // trig_q resets high so a trigger held through reset release is not an edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q  <= '0;
            trig_q <= '1;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            trig_q <= trig;
        end
    end

    assign trigRise = trig & ~trig_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        logic [SEL_W-1:0] selK;
        logic [1:0]       modeK;
        logic [4:0]       sEff;
        logic             tickK;
        logic             blinkK;
        logic [1:0]       state_q, state_d;
        logic [BW-1:0]    pulses_q, pulses_d;
        logic             led_q, led_d;
        logic             busy_q, busy_d;

        assign selK  = sel[SEL_W*k +: SEL_W];
        assign modeK = mode[2*k +: 2];

        // Exponent clamped to the counter width; tick fires when the low s bits are all ones
        always_comb begin
            sEff   = (32'(selK) > 32'(CNT_W - 1)) ? 5'(CNT_W - 1) : 5'(selK);
            tickK  = 1'b1;
            blinkK = 1'b0;
            for (int b = 0; b < CNT_W; b++) begin
                if (b < int'(sEff) && !cnt_q[b]) tickK = 1'b0;
                if (b == int'(sEff)) blinkK = cnt_q[b];
            end
        end

        always_comb begin
            state_d  = state_q;
            pulses_d = pulses_q;
            led_d    = 1'b0;
            case (modeK)
                2'b00: begin
                    state_d  = ST_IDLE;
                    pulses_d = '0;
                    led_d    = 1'b0;
                end
                2'b01: begin
                    state_d  = ST_IDLE;
                    pulses_d = '0;
                    led_d    = 1'b1;
                end
                2'b10: begin
                    state_d  = ST_IDLE;
                    pulses_d = '0;
                    led_d    = blinkK;
                end
                default: begin
                    case (state_q)
                        ST_IDLE: if (trigRise[k]) begin
                            state_d  = ST_WAIT;
                            pulses_d = BURST_LOAD;
                        end
                        ST_WAIT: if (tickK) state_d = ST_ON;
                        ST_ON: if (tickK) begin
                            state_d  = ST_OFF;
                            pulses_d = pulses_q - BW'(1);
                        end
                        default: if (tickK) state_d = (pulses_q != '0) ? ST_ON : ST_IDLE;
                    endcase
                    led_d = (state_d == ST_ON);
                end
            endcase
            busy_d = (state_d != ST_IDLE);
        end

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                state_q  <= ST_IDLE;
                pulses_q <= '0;
                led_q    <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                state_q  <= state_d;
                pulses_q <= pulses_d;
                led_q    <= led_d;
                busy_q   <= busy_d;
            end
        end

        assign ledRaw[k] = led_q;
        assign busy[k]   = busy_q;
    end

    assign led = ledRaw ^ {NUM_CH{ACTIVE_LOW}};

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized bench for led_sequencer: two instances (active-high and active-low)
// share stimulus and are compared each cycle against a segment-counting model.
module tb_led_sequencer;
    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int SEL_W   = 5;
    localparam int BURST_N = 3;

    logic sysClk = 1'b0;
    logic sysRst;
    logic [2*NUM_CH-1:0]     mode;
    logic [SEL_W*NUM_CH-1:0] sel;
    logic [NUM_CH-1:0]       trig;
    logic [NUM_CH-1:0]       ledHi, busyHi, ledLo, busyLo;

    int checks = 0;
    int errors = 0;

    int modelCnt;
    logic [NUM_CH-1:0] trigPrev;
    int seg [NUM_CH];
    logic [NUM_CH-1:0] expLed, expBusy;

    always #5 sysClk = ~sysClk;

    led_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W), .BURST_N(BURST_N), .ACTIVE_LOW(1'b0)) dutHi (
        .sys_clk(sysClk), .sys_rst(sysRst), .mode(mode), .sel(sel), .trig(trig),
        .led(ledHi), .busy(busyHi)
    );

    led_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W), .BURST_N(BURST_N), .ACTIVE_LOW(1'b1)) dutLo (
        .sys_clk(sysClk), .sys_rst(sysRst), .mode(mode), .sel(sel), .trig(trig),
        .led(ledLo), .busy(busyLo)
    );

    function automatic void modelReset();
        modelCnt = 0;
        trigPrev = '1;
        for (int k = 0; k < NUM_CH; k++) seg[k] = -1;
        expLed  = '0;
        expBusy = '0;
    endfunction

    // A burst is 2*BURST_N+1 tick-delimited segments: wait, then alternating on/off
    function automatic void modelStep();
        for (int k = 0; k < NUM_CH; k++) begin
            int s;
            int period;
            bit tick;
            bit rise;
            logic [1:0] m;
            s = int'(sel[SEL_W*k +: SEL_W]);
            if (s > CNT_W - 1) s = CNT_W - 1;
            period = 1 << s;
            tick = ((modelCnt % period) == period - 1);
            m = mode[2*k +: 2];
            rise = trig[k] && !trigPrev[k];
            if (m != 2'b11) seg[k] = -1;
            case (m)
                2'b00: expLed[k] = 1'b0;
                2'b01: expLed[k] = 1'b1;
                2'b10: expLed[k] = ((modelCnt / period) % 2) == 1;
                default: begin
                    if (seg[k] < 0) begin
                        if (rise) seg[k] = 0;
                    end else if (tick) begin
                        seg[k] = seg[k] + 1;
                        if (seg[k] > 2 * BURST_N) seg[k] = -1;
                    end
                    expLed[k] = (seg[k] >= 1) && ((seg[k] % 2) == 1);
                end
            endcase
            expBusy[k] = (seg[k] >= 0);
        end
        trigPrev = trig;
        modelCnt = (modelCnt + 1) % (1 << CNT_W);
    endfunction

    task automatic applyStimulus();
        if (sysRst) modelReset();
        else modelStep();
        @(posedge sysClk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (ledHi === expLed) else begin
            errors++;
            $error("FAIL %s ledHi: got %b expected %b", tag, ledHi, expLed);
        end
        checks++;
        assert (busyHi === expBusy) else begin
            errors++;
            $error("FAIL %s busyHi: got %b expected %b", tag, busyHi, expBusy);
        end
        checks++;
        assert (ledLo === ~expLed) else begin
            errors++;
            $error("FAIL %s ledLo: got %b expected %b", tag, ledLo, ~expLed);
        end
        checks++;
        assert (busyLo === expBusy) else begin
            errors++;
            $error("FAIL %s busyLo: got %b expected %b", tag, busyLo, expBusy);
        end
    endtask

    task automatic runCycles(input int n, input string tag);
        repeat (n) begin
            applyStimulus();
            checkOutput(tag);
        end
    endtask

    initial begin
        sysRst = 1'b1;
        mode   = '0;
        sel    = '0;
        trig   = '0;
        runCycles(3, "reset");
        sysRst = 1'b0;

        mode[1:0] = 2'b10;
        sel[4:0]  = 5'd2;
        runCycles(40, "blink");

        mode[3:2] = 2'b11;
        sel[9:5]  = 5'd1;
        trig[1]   = 1'b1;
        runCycles(1, "burstTrig");
        trig[1]   = 1'b0;
        runCycles(8, "burst");
        trig[1]   = 1'b1;
        runCycles(1, "retrigger");
        trig[1]   = 1'b0;
        runCycles(40, "burstEnd");

        trig[1] = 1'b1;
        runCycles(1, "secondTrig");
        trig[1] = 1'b0;
        runCycles(40, "secondBurst");

        trig[1] = 1'b1;
        runCycles(1, "abortTrig");
        trig[1] = 1'b0;
        for (int i = 0; i < 20 && !expLed[1]; i++) runCycles(1, "abortWait");
        mode[3:2] = 2'b00;
        runCycles(3, "abort");

        mode[3:2] = 2'b11;
        trig[1]   = 1'b1;
        runCycles(1, "resetTrig");
        trig[1]   = 1'b0;
        runCycles(5, "preReset");
        sysRst = 1'b1;
        trig   = '1;
        runCycles(2, "midReset");
        sysRst = 1'b0;
        runCycles(20, "trigHeld");
        trig = '0;

        mode[5:4]  = 2'b10;
        sel[14:10] = 5'd31;
        runCycles(600, "clampWrap");
        sel[4:0] = 5'd0;
        runCycles(10, "sel0");

        repeat (3000) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 63) == 0) mode[2*k +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 63) == 0)
                    sel[SEL_W*k +: SEL_W] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) trig[k] = ~trig[k];
            end
            sysRst = ($urandom_range(0, 499) == 0);
            runCycles(1, "random");
        end
        sysRst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
